// File: rtl/mipi_csi_rx_packet_decoder_8b2lane_pkg.sv
// Shared CSI-2 receive definitions: data type codes, short/long split, decoder states.
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_RAW12    = 6'h2C;
    localparam logic [5:0] DT_RAW14    = 6'h2D;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR      = 2'd1,
        PAYLOAD  = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    function automatic logic is_raw_dt(input logic [5:0] dt);
        return (dt == DT_RAW10) || (dt == DT_RAW12) || (dt == DT_RAW14);
    endfunction

endpackage

// File: rtl/mipi_csi_rx_header_ecc.sv
// CSI-2 packet header Hamming parity: 24 header bits in, 6 parity bits out.
// Purely combinational, no state; shared by the receiver and the TX test model.
module mipi_csi_rx_header_ecc (
    input  logic [23:0] data_i,
    output logic [5:0]  ecc_o
);

    logic [23:0] w_d;
    assign w_d = data_i;

    assign ecc_o[0] = w_d[0]  ^ w_d[1]  ^ w_d[2]  ^ w_d[4]  ^ w_d[5]  ^ w_d[7]  ^ w_d[10]
                    ^ w_d[11] ^ w_d[13] ^ w_d[16] ^ w_d[20] ^ w_d[21] ^ w_d[22] ^ w_d[23];
    assign ecc_o[1] = w_d[0]  ^ w_d[1]  ^ w_d[3]  ^ w_d[4]  ^ w_d[6]  ^ w_d[8]  ^ w_d[10]
                    ^ w_d[12] ^ w_d[14] ^ w_d[17] ^ w_d[20] ^ w_d[21] ^ w_d[22] ^ w_d[23];
    assign ecc_o[2] = w_d[0]  ^ w_d[2]  ^ w_d[3]  ^ w_d[5]  ^ w_d[6]  ^ w_d[9]  ^ w_d[11]
                    ^ w_d[12] ^ w_d[15] ^ w_d[18] ^ w_d[20] ^ w_d[21] ^ w_d[22];
    assign ecc_o[3] = w_d[1]  ^ w_d[2]  ^ w_d[3]  ^ w_d[7]  ^ w_d[8]  ^ w_d[9]  ^ w_d[13]
                    ^ w_d[14] ^ w_d[15] ^ w_d[19] ^ w_d[20] ^ w_d[21] ^ w_d[23];
    assign ecc_o[4] = w_d[4]  ^ w_d[5]  ^ w_d[6]  ^ w_d[7]  ^ w_d[8]  ^ w_d[9]  ^ w_d[16]
                    ^ w_d[17] ^ w_d[18] ^ w_d[19] ^ w_d[20] ^ w_d[22] ^ w_d[23];
    assign ecc_o[5] = w_d[10] ^ w_d[11] ^ w_d[12] ^ w_d[13] ^ w_d[14] ^ w_d[15] ^ w_d[16]
                    ^ w_d[17] ^ w_d[18] ^ w_d[19] ^ w_d[21] ^ w_d[22] ^ w_d[23];

endmodule

// File: rtl/mipi_csi_rx_packet_decoder_8b2lane.sv
// CSI-2 2-lane packet decoder: header/ECC/VC/DT filtering, FS/FE pulses, RAW payload streaming.
// Payload latency 1 cycle; no backpressure, a burst dropping early ends the packet (abort in payload).
module mipi_csi_rx_packet_decoder_8b2lane
    import mipi_csi_pkg::*;
#(
    parameter logic [1:0] VC_ID     = 2'd0,
    parameter bit          ECC_CHECK = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [15:0] data_i,
    output logic        output_valid_o,
    output logic [15:0] output_o,
    output logic [2:0]  packet_type_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        ecc_error_o,
    output logic        abort_o
);

    state_t      r_state;
    logic [7:0]  r_di;
    logic [7:0]  r_wc_lo;
    logic [15:0] r_rem;
    logic        r_dv_prev;

    logic [23:0] w_hdr;
    logic [5:0]  w_ecc;
    logic        w_ecc_bad;
    logic [1:0]  w_vc;
    logic [5:0]  w_dt;
    logic [15:0] w_wc;

    assign w_hdr     = {data_i[7:0], r_wc_lo, r_di};
    assign w_vc      = r_di[7:6];
    assign w_dt      = r_di[5:0];
    assign w_wc      = {data_i[7:0], r_wc_lo};
    assign w_ecc_bad = ECC_CHECK && (w_ecc != data_i[13:8]);

    mipi_csi_rx_header_ecc u_ecc (
        .data_i (w_hdr),
        .ecc_o  (w_ecc)
    );

    // r_dv_prev resets high so a burst already in flight at reset release is skipped.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= IDLE;
            r_di           <= 8'h00;
            r_wc_lo        <= 8'h00;
            r_rem          <= 16'h0000;
            r_dv_prev      <= 1'b1;
            output_valid_o <= 1'b0;
            output_o       <= 16'h0000;
            packet_type_o  <= 3'h0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            ecc_error_o    <= 1'b0;
            abort_o        <= 1'b0;
        end else begin
            r_dv_prev      <= data_valid_i;
            output_valid_o <= 1'b0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            ecc_error_o    <= 1'b0;
            abort_o        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_valid_i && !r_dv_prev) begin
                        r_di    <= data_i[7:0];
                        r_wc_lo <= data_i[15:8];
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (!data_valid_i) begin
                        r_state <= IDLE;
                    end else if (w_ecc_bad) begin
                        ecc_error_o <= 1'b1;
                        r_state     <= WAIT_END;
                    end else if (w_vc != VC_ID) begin
                        r_state <= WAIT_END;
                    end else if (w_dt == DT_FS) begin
                        frame_start_o <= 1'b1;
                        r_state       <= WAIT_END;
                    end else if (w_dt == DT_FE) begin
                        frame_end_o <= 1'b1;
                        r_state     <= WAIT_END;
                    end else if (w_dt < DT_LONG_MIN) begin
                        r_state <= WAIT_END;
                    end else if (is_raw_dt(w_dt) && (w_wc != 16'h0000)) begin
                        r_rem         <= w_wc;
                        packet_type_o <= w_dt[2:0];
                        r_state       <= PAYLOAD;
                    end else begin
                        r_state <= WAIT_END;
                    end
                end
                PAYLOAD: begin
                    if (!data_valid_i) begin
                        abort_o <= 1'b1;
                        r_rem   <= 16'h0000;
                        r_state <= IDLE;
                    end else begin
                        output_valid_o <= 1'b1;
                        // One byte left means odd word count: only lane0 carries payload.
                        output_o <= (r_rem == 16'd1) ? {8'h00, data_i[7:0]} : data_i;
                        if (r_rem <= 16'd2) begin
                            r_rem   <= 16'h0000;
                            r_state <= WAIT_END;
                        end else begin
                            r_rem <= r_rem - 16'd2;
                        end
                    end
                end
                WAIT_END: begin
                    if (!data_valid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_8b2lane.sv
// Directed bench for the CSI-2 packet decoder; two instances differ only in header ECC checking.
module tb_mipi_csi_rx_packet_decoder_8b2lane;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        data_valid_i;
    logic [15:0] data_i;

    logic        output_valid_o, frame_start_o, frame_end_o, ecc_error_o, abort_o;
    logic [15:0] output_o;
    logic [2:0]  packet_type_o;
    logic        nc_valid, nc_fs, nc_fe, nc_ecc, nc_abort;
    logic [15:0] nc_out;
    logic [2:0]  nc_pt;

    always #5 clk_i = ~clk_i;

    mipi_csi_rx_packet_decoder_8b2lane #(.VC_ID(2'd0), .ECC_CHECK(1'b1)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .data_valid_i(data_valid_i), .data_i(data_i),
        .output_valid_o(output_valid_o), .output_o(output_o), .packet_type_o(packet_type_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .ecc_error_o(ecc_error_o), .abort_o(abort_o)
    );

    mipi_csi_rx_packet_decoder_8b2lane #(.VC_ID(2'd0), .ECC_CHECK(1'b0)) dut_nc (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .data_valid_i(data_valid_i), .data_i(data_i),
        .output_valid_o(nc_valid), .output_o(nc_out), .packet_type_o(nc_pt),
        .frame_start_o(nc_fs), .frame_end_o(nc_fe),
        .ecc_error_o(nc_ecc), .abort_o(nc_abort)
    );

    int total = 0;
    int bad   = 0;

    // Per-test observation counters, sampled mid-cycle on the falling edge.
    int          cyc = 0;
    int          n_valid, n_runs, n_fs, n_fe, n_ecc, n_abort, n_nc_valid, n_nc_ecc;
    int          first_cyc, mark;
    logic [2:0]  pt_before, last_pt;
    logic        prev_valid;
    logic [15:0] words[$];
    logic [15:0] stim[$];
    logic [15:0] exp_w[$];

    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (output_valid_o) begin
            n_valid = n_valid + 1;
            words.push_back(output_o);
            if (!prev_valid) n_runs = n_runs + 1;
            if (first_cyc < 0) begin
                first_cyc = cyc;
                pt_before = last_pt;
            end
        end
        if (frame_start_o) n_fs = n_fs + 1;
        if (frame_end_o)   n_fe = n_fe + 1;
        if (ecc_error_o)   n_ecc = n_ecc + 1;
        if (abort_o)       n_abort = n_abort + 1;
        if (nc_valid)      n_nc_valid = n_nc_valid + 1;
        if (nc_ecc)        n_nc_ecc = n_nc_ecc + 1;
        prev_valid = output_valid_o;
        last_pt    = packet_type_o;
    end

    task automatic clear_obs();
        n_valid = 0; n_runs = 0; n_fs = 0; n_fe = 0; n_ecc = 0; n_abort = 0;
        n_nc_valid = 0; n_nc_ecc = 0; first_cyc = -1; mark = -100;
        words.delete();
    endtask

    task automatic drive(input logic dv, input logic [15:0] d);
        @(posedge clk_i);
        #1;
        data_valid_i = dv;
        data_i       = d;
    endtask

    // Sends stim[] as one burst, then idles long enough for outputs to settle.
    task automatic send_burst();
        for (int i = 0; i < stim.size(); i++) begin
            drive(1'b1, stim[i]);
            if (i == 2) mark = cyc;
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000);
    endtask

    task automatic check_words(input string name);
        total++;
        if (words.size() != exp_w.size()) begin
            bad++;
            $display("FAIL %s word count: got %0d want %0d", name, words.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size(); i++) begin
            logic [15:0] got;
            got = (i < words.size()) ? words[i] : 16'hxxxx;
            total++;
            if (got !== exp_w[i]) begin
                bad++;
                $display("FAIL %s word %0d: got %h want %h", name, i, got, exp_w[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; data_valid_i = 1'b0; data_i = 16'h0000;
        clear_obs();
        #3;
        total++;
        if ({output_valid_o, output_o, packet_type_o, frame_start_o, frame_end_o, ecc_error_o, abort_o} !== 24'h0) begin
            bad++;
            $display("FAIL reset outputs: got v=%b d=%h pt=%h fs=%b fe=%b ecc=%b ab=%b want all 0",
                     output_valid_o, output_o, packet_type_o, frame_start_o, frame_end_o, ecc_error_o, abort_o);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (2) drive(1'b0, 16'h0000);
    endtask

    task automatic test_frame_markers();
        clear_obs();
        stim = '{16'h0000, 16'h0000};
        send_burst();
        total++; if (n_fs !== 1) begin bad++; $display("FAIL fs pulse: got %0d cycles want 1", n_fs); end
        total++; if (n_valid !== 0) begin bad++; $display("FAIL fs valid: got %0d want 0", n_valid); end
        clear_obs();
        stim = '{16'h0001, 16'h0700};
        send_burst();
        total++; if (n_fe !== 1) begin bad++; $display("FAIL fe pulse: got %0d cycles want 1", n_fe); end
        total++; if (n_fs !== 0) begin bad++; $display("FAIL fe no fs: got %0d want 0", n_fs); end
    endtask

    task automatic test_raw10();
        clear_obs();
        stim  = '{16'h0A2B, 16'h2E00, 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'hBEEF};
        exp_w = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09};
        send_burst();
        total++; if (n_valid !== 5) begin bad++; $display("FAIL raw10 valid: got %0d want 5", n_valid); end
        total++; if (n_runs !== 1) begin bad++; $display("FAIL raw10 runs: got %0d want 1", n_runs); end
        total++; if (first_cyc !== mark + 2) begin bad++; $display("FAIL raw10 latency: got %0d want %0d", first_cyc, mark + 2); end
        total++; if (pt_before !== 3'h3) begin bad++; $display("FAIL raw10 pt before valid: got %h want 3", pt_before); end
        check_words("raw10");
    endtask

    task automatic test_ecc_error();
        clear_obs();
        stim = '{16'h0A2B, 16'h2F00, 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'hBEEF};
        send_burst();
        total++; if (n_ecc !== 1) begin bad++; $display("FAIL ecc pulse: got %0d want 1", n_ecc); end
        total++; if (n_valid !== 0) begin bad++; $display("FAIL ecc valid: got %0d want 0", n_valid); end
        total++; if (packet_type_o !== 3'h3) begin bad++; $display("FAIL ecc pt held: got %h want 3", packet_type_o); end
        total++; if (n_nc_valid !== 5) begin bad++; $display("FAIL nocheck valid: got %0d want 5", n_nc_valid); end
        total++; if (n_nc_ecc !== 0) begin bad++; $display("FAIL nocheck ecc: got %0d want 0", n_nc_ecc); end
    endtask

    task automatic test_vc_filter();
        clear_obs();
        stim = '{16'h0A6B, 16'h3800, 16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'hBEEF};
        send_burst();
        total++; if (n_valid !== 0) begin bad++; $display("FAIL vc1 valid: got %0d want 0", n_valid); end
        total++; if (n_ecc !== 0) begin bad++; $display("FAIL vc1 ecc: got %0d want 0", n_ecc); end
        clear_obs();
        stim  = '{16'h0A2B, 16'h2E00, 16'h1201, 16'h1403, 16'h1605, 16'h1807, 16'h1A09, 16'hBEEF};
        exp_w = '{16'h1201, 16'h1403, 16'h1605, 16'h1807, 16'h1A09};
        send_burst();
        check_words("vc0 after vc1");
    endtask

    task automatic test_abort_then_raw12();
        clear_obs();
        stim = '{16'h0A2B, 16'h2E00, 16'h0201, 16'h0403};
        send_burst();
        total++; if (n_valid !== 2) begin bad++; $display("FAIL abort valid: got %0d want 2", n_valid); end
        total++; if (n_abort !== 1) begin bad++; $display("FAIL abort pulse: got %0d want 1", n_abort); end
        clear_obs();
        stim  = '{16'h062C, 16'h2900, 16'h1111, 16'h2222, 16'h3333, 16'hCAFE};
        exp_w = '{16'h1111, 16'h2222, 16'h3333};
        send_burst();
        total++; if (pt_before !== 3'h4) begin bad++; $display("FAIL raw12 pt before valid: got %h want 4", pt_before); end
        total++; if (n_runs !== 1) begin bad++; $display("FAIL raw12 runs: got %0d want 1", n_runs); end
        total++; if (n_abort !== 0) begin bad++; $display("FAIL raw12 abort: got %0d want 0", n_abort); end
        check_words("raw12");
    endtask

    task automatic test_odd_wc();
        clear_obs();
        stim  = '{16'h032B, 16'h1100, 16'hAABB, 16'hCCDD, 16'h5A5A};
        exp_w = '{16'hAABB, 16'h00DD};
        send_burst();
        check_words("odd wc");
    endtask

    task automatic test_reset_mid_payload();
        clear_obs();
        drive(1'b1, 16'h0A2B);
        drive(1'b1, 16'h2E00);
        drive(1'b1, 16'h0201);
        drive(1'b1, 16'h0403);
        @(posedge clk_i);
        #2;
        total++; if (output_valid_o !== 1'b1) begin bad++; $display("FAIL midreset pre valid: got %b want 1", output_valid_o); end
        reset_n_i = 1'b0;
        #1;
        total++;
        if ({output_valid_o, output_o, packet_type_o} !== 20'h0) begin
            bad++;
            $display("FAIL midreset clear: got v=%b d=%h pt=%h want 0", output_valid_o, output_o, packet_type_o);
        end
        drive(1'b1, 16'h0605);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        clear_obs();
        drive(1'b1, 16'h0807);
        drive(1'b1, 16'h0A09);
        drive(1'b1, 16'hBEEF);
        repeat (4) drive(1'b0, 16'h0000);
        total++; if (n_valid !== 0) begin bad++; $display("FAIL inflight ignored: got %0d valid want 0", n_valid); end
        clear_obs();
        stim  = '{16'h062C, 16'h2900, 16'h7771, 16'h7772, 16'h7773, 16'hCAFE};
        exp_w = '{16'h7771, 16'h7772, 16'h7773};
        send_burst();
        total++; if (packet_type_o !== 3'h4) begin bad++; $display("FAIL post reset pt: got %h want 4", packet_type_o); end
        check_words("post reset");
    endtask

    initial begin
        test_reset();
        test_frame_markers();
        test_raw10();
        test_ecc_error();
        test_vc_filter();
        test_abort_then_raw12();
        test_odd_wc();
        test_reset_mid_payload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mipi_csi_rx_packet_decoder_8b2lane.md
Name: mipi_csi_rx_packet_decoder_8b2lane

Overview:
- Sits between the 2-lane byte/lane aligner and the RAW depacker (mipi_csi_rx_raw_depacker_8b2lane_2ppc).
- Parses the CSI-2 packet header from aligned 2-lane byte pairs, checks the header ECC, filters on virtual channel and data type, and signals frame start/end.
- For accepted RAW long packets, strips header and CRC and streams payload byte pairs in the depacker's input format: data valid, 16-bit data, 3-bit packet type.

Parameters:
- VC_ID, 2'd0: virtual channel accepted; packets on other VCs are ignored.
- ECC_CHECK, 1: 1 = drop packets whose header ECC mismatches; 0 = ignore the ECC byte.

Ports:
- clk_i  in  1  byte clock; single clock domain.
- reset_n_i  in  1  asynchronous, active-low reset.
- data_valid_i  in  1  aligner output; high for the duration of one HS burst; exactly one packet per burst.
- data_i  in  16  lane0 byte in [7:0], lane1 byte in [15:8]; first valid cycle carries header bytes 0,1.
- output_valid_o  out  1  payload byte pair valid; one continuous high run per accepted line.
- output_o  out  16  payload bytes, lane0 byte in [7:0].
- packet_type_o  out  3  data type & 3'h7 of the last accepted long packet; held between packets.
- frame_start_o  out  1  one-cycle pulse on a Frame Start short packet (DT 0x00).
- frame_end_o  out  1  one-cycle pulse on a Frame End short packet (DT 0x01).
- ecc_error_o  out  1  one-cycle pulse on a header ECC mismatch.
- abort_o  out  1  one-cycle pulse when data_valid_i falls before the payload completes.

Behaviour:
- Reset: async assert drives all outputs to 0, state to IDLE and the byte counter to 0; release is used synchronously.
- Header layout: DI = data_i[7:0] and WC_lo = data_i[15:8] on cycle H0; WC_hi = data_i[7:0] and ECC = data_i[15:8] on cycle H1. VC = DI[7:6], DT = DI[5:0].
- ECC rule:
  - ecc6 = CSI-2 Hamming parity over D[23:0] = {WC_hi, WC_lo, DI}.
  - Mismatch vs ECC[5:0] when ECC_CHECK=1 -> ecc_error_o pulse; packet discarded.
  - ECC[7:6] are not checked.
- States:
  - IDLE: on data_valid_i=1, latch byte 0 and 1 -> HDR.
  - HDR: evaluate the full header on the H1 cycle. Decision order:
    - ECC error -> WAIT_END.
    - VC != VC_ID -> WAIT_END.
    - DT 0x00/0x01 -> pulse frame_start_o/frame_end_o, -> WAIT_END.
    - Other short packets (DT < 0x10) -> WAIT_END.
    - DT 0x2B/0x2C/0x2D with WC != 0 -> load remaining = WC, set packet_type_o = DT[2:0] -> PAYLOAD.
    - Any other long packet, or WC = 0 -> WAIT_END.
  - PAYLOAD: each valid input cycle, register data_i to output_o with output_valid_o=1 (latency 1 cycle) and subtract 2 from remaining. When remaining <= 2, that cycle is the last word -> WAIT_END.
  - WAIT_END: ignore CRC and trailer bytes until data_valid_i=0 -> IDLE.
- Odd WC: the final word outputs only lane0; output_o[15:8] is forced to 0.
- packet_type_o changes only in the HDR cycle of an accepted packet, so it is stable at least 1 cycle before output_valid_o rises; the depacker samples it while its own valid is low.
- data_valid_i=0 in HDR or PAYLOAD:
  - Go to IDLE on the next edge; output_valid_o=0.
  - Pulse abort_o only if in PAYLOAD.
  - Drop the partial header.
- data_valid_i=0 in IDLE or WAIT_END: no action beyond the WAIT_END -> IDLE exit.
- output_valid_o never toggles inside a packet; the depacker relies on a contiguous valid run per line.
- Remaining counter is 16 bits and saturates at 0; no wrap.
- Mid-packet reset: outputs cleared immediately; the first packet after release is decoded only if data_valid_i rises after release (a burst already in flight is ignored until data_valid_i goes low).

Decomposition:
- Shared package mipi_csi_pkg holds:
  - DT constants: FS 0x00, FE 0x01, RAW10 0x2B, RAW12 0x2C, RAW14 0x2D.
  - Short/long threshold 0x10.
  - State enum {IDLE, HDR, PAYLOAD, WAIT_END}.
- One sub-module: mipi_csi_rx_header_ecc, combinational: 24-bit in, 6-bit ECC out. It is reused by the TX test model.

Test Plan:
- FS: H0 {0x00,0x00}, H1 {0x00,0x00}, ECC 0x00 -> frame_start_o high for exactly 1 cycle. No output_valid_o. FE with DI=0x01, ECC=0x07 -> frame_end_o single pulse.
- RAW10, DI=0x2B, WC=0x000A, correct ECC, payload 0x0201,0x0403,0x0605,0x0807,0x0A09 then CRC -> packet_type_o=3'h3 before valid; output_valid_o high exactly 5 consecutive cycles, starting 1 cycle after the first payload word; output_o equals the payload in order; CRC not output.
- Same header with ECC bit 0 flipped -> ecc_error_o single pulse, no output_valid_o, packet_type_o unchanged. With ECC_CHECK=0 -> 5 words output.
- DI=0x6B (VC=1, RAW10) with VC_ID=0 -> no outputs. A following VC0 packet decodes normally.
- WC=10, data_valid_i dropped after 2 payload words -> 2 valid words, then abort_o pulse; next burst with RAW12 (DT 0x2C, WC=6) -> packet_type_o=3'h4 and 3 valid words.
- Odd WC=3 -> 2 valid words, second with output_o[15:8]=0. reset_n_i asserted mid-payload -> all outputs 0 in the same cycle.
